// File: rtl/score_display_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : score_display_driver_if                                    |
// | Description : Bundles the game-control inputs (hit, clr) and the display |
// |               / score outputs of score_display_driver.                   |
// |   master : game control side, drives hit/clr, observes display + score   |
// |   slave  : score_display_driver side                                     |
// |   hit       1   single-cycle pulse, add 1 to the score                    |
// |   clr       1   synchronous score clear, wins over hit                    |
// |   bcd_digit 4   BCD digit for the 7-segment decoder Y input               |
// |   an        4   active-low anode enables, an[0] = units                   |
// |   score     16  packed BCD score {thousands, hundreds, tens, units}       |
// |   sat       1   sticky saturation flag (score reached 9999 and was hit)   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface score_display_driver_if;
   logic        hit;
   logic        clr;
   logic [3:0]  bcd_digit;
   logic [3:0]  an;
   logic [15:0] score;
   logic        sat;

   modport master (
      output hit,
      output clr,
      input  bcd_digit,
      input  an,
      input  score,
      input  sat
   );

   modport slave (
      input  hit,
      input  clr,
      output bcd_digit,
      output an,
      output score,
      output sat
   );
endinterface
`default_nettype wire

// File: rtl/score_display_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : score_display_driver                                       |
// | Description : Holds a 4-digit BCD score and time-multiplexes its digits  |
// |               onto a 4-digit common-anode display.                       |
// |   clk    in   system clock                                              |
// |   rst_n  in   asynchronous active-low reset                              |
// |   bus    slave modport of score_display_driver_if                        |
// |          (hit/clr in; bcd_digit/an/score/sat out)                        |
// | Parameters  : SCAN_DIV  clock cycles per digit slot (2..2^20)            |
// |               BLANK_LZ  1 = blank leading-zero digits                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module score_display_driver #(
   parameter int SCAN_DIV = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   score_display_driver_if.slave bus
);

   localparam int                 c_cnt_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
   localparam logic [15:0]        c_score_max = 16'h9999;

   // ---------------------------------------------------------------- state
   logic [15:0]        r_score;
   logic               r_sat;
   logic [c_cnt_w-1:0] r_scan_cnt;
   logic [1:0]         r_idx;
   logic [3:0]         r_bcd;
   logic [3:0]         r_an;

   // ------------------------------------------------------- combinational
   logic [15:0] w_score_inc;
   logic        w_scan_wrap;
   logic [3:0]  w_zero_from;   // bit i: nibbles i..3 are all zero
   logic        w_blank;
   logic [3:0]  w_sel_nib;
   logic [3:0]  w_an_onehot;

   // BCD ripple increment: each nibble rolls 9->0 and passes the carry on,
   // so every nibble stays within 0..9.
   always_comb begin
      logic carry;
      w_score_inc = r_score;
      carry       = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r_score[4*i +: 4] == 4'd9) begin
               w_score_inc[4*i +: 4] = 4'd0;
            end else begin
               w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
               carry                 = 1'b0;
            end
         end
      end
   end

   assign w_scan_wrap = (r_scan_cnt == c_cnt_last);

   // Leading-zero detection from the most significant digit downwards.
   assign w_zero_from[3] = (r_score[15:12] == 4'd0);
   assign w_zero_from[2] = w_zero_from[3] & (r_score[11:8] == 4'd0);
   assign w_zero_from[1] = w_zero_from[2] & (r_score[7:4]  == 4'd0);
   assign w_zero_from[0] = w_zero_from[1] & (r_score[3:0]  == 4'd0);

   // Units digit (index 0) is never blanked so a zero score still shows "0".
   assign w_blank     = BLANK_LZ && (r_idx != 2'd0) && w_zero_from[r_idx];
   assign w_sel_nib   = r_score[{r_idx, 2'b00} +: 4];
   assign w_an_onehot = ~(4'b0001 << r_idx);

   // ---------------------------------------------------------- score path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score <= 16'h0000;
         r_sat   <= 1'b0;
      end else if (bus.clr) begin
         r_score <= 16'h0000;
         r_sat   <= 1'b0;
      end else if (bus.hit) begin
         if (r_score == c_score_max) begin
            r_sat <= 1'b1;
         end else begin
            r_score <= w_score_inc;
         end
      end
   end

   // ------------------------------------------------------------ scanning
   // Free-running; independent of hit and clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= 2'd0;
      end else if (w_scan_wrap) begin
         r_scan_cnt <= '0;
         r_idx      <= r_idx + 2'd1;
      end else begin
         r_scan_cnt <= r_scan_cnt + c_cnt_w'(1);
      end
   end

   // -------------------------------------------------------- output stage
   // Digit and anode are registered together so they always change on the
   // same edge; a blanked slot keeps every anode high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bcd <= 4'd0;
         r_an  <= 4'b1110;
      end else begin
         r_bcd <= w_sel_nib;
         r_an  <= w_blank ? 4'b1111 : w_an_onehot;
      end
   end

   assign bus.score     = r_score;
   assign bus.sat       = r_sat;
   assign bus.bcd_digit = r_bcd;
   assign bus.an        = r_an;

endmodule
`default_nettype wire

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
Upstream neighbour of the BCD-to-7-segment decoder on the Basys 3 board. Holds the 4-digit BCD Whack-a-Mole score and time-multiplexes its digits onto the 4-digit common-anode display. Each cycle it emits one 4-bit BCD digit to the decoder's Y input and drives the matching active-low anode. Hit pulses come from game control.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit, 250 Hz full refresh at 100 MHz); legal range 2..2^20.
BLANK_LZ, 1, 1 = blank leading-zero digits (anode held high); 0 = show all four digits.

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
hit  input  1  single-cycle pulse; add 1 to score
clr  input  1  synchronous score clear; has priority over hit
bcd_digit  output  4  BCD digit for the decoder Y input; always 0..9
an  output  4  anode enables, active-low; an[0] = units digit
score  output  16  packed BCD score {thousands, hundreds, tens, units}
sat  output  1  sticky flag: score has saturated at 9999

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low on rst_n. All flops clear immediately when rst_n falls.
- Reset values: score=16'h0000, sat=0, scan counter=0, digit index=0, bcd_digit=4'd0, an=4'b1110.
- Score register:
  - clr=1: score<=0 and sat<=0 on that edge; hit ignored.
  - hit=1, clr=0, score<9999: BCD increment. A units carry 9->0 propagates to tens, then hundreds, then thousands in the same cycle.
  - hit=1 at 9999: score holds 9999 and sat<=1. No wrap.
  - Each nibble must stay 0..9 at all times.
  - hit held high for N cycles gives N increments (not edge-detected).
- Scan counter:
  - Counts 0..SCAN_DIV-1 every cycle, then wraps to 0.
  - On the wrap cycle, digit index advances 0->1->2->3->0.
  - Scan runs freely and is unaffected by hit and clr.
- Output stage (registered; 1-cycle latency from index or score change):
  - bcd_digit <= score nibble selected by index (index 0 = bits [3:0]).
  - an <= one-hot-low for index, e.g. index 2 gives 4'b1011.
  - Blanking when BLANK_LZ=1: digit i>0 is blanked if all nibbles i..3 are zero. Blanking forces an=4'b1111; bcd_digit still carries the selected nibble (0).
  - Units digit is never blanked, so score 0 shows a single "0".
- Never more than one anode low in any cycle.
- No glitching on digit change: an and bcd_digit update on the same edge.
- A score change mid-slot shows on the next cycle's output.
- Reset mid-scan returns index to 0 and the display to units-only "0" immediately.

Test Plan:
- Use SCAN_DIV=4 in the bench.
- Reset, 20 idle cycles -> score=0000; an cycles 1110 then 1111 x3 (blanked), each slot 4 cycles long; bcd_digit=0.
- 123 hit pulses -> score=16'h0123. Over one full scan: an=1110/bcd 3, 1101/bcd 2, 1011/bcd 1, 1111 (thousands blanked).
- Preload to 0999 with hits, one more hit -> score=16'h1000 on the next edge; all four anodes active in turn with bcd 0,0,0,1.
- At 9999, hit for 3 cycles -> score stays 16'h9999, sat=1. Then clr -> score=0, sat=0.
- hit and clr high together at score 0042 -> score=0000.
- Assert rst_n low mid-slot with index=2 -> an=1110, bcd_digit=0, score=0 without waiting for a clock edge. Release -> scan restarts at index 0.
- BLANK_LZ=0, score 0007 -> all four anodes scanned, bcd 7,0,0,0. Check bcd_digit never exceeds 9 across a random hit/clr run.
